// File: rtl/back_sprite_ctrl.sv
// Battle back-sprite controller: slide-in, idle bob, hit blink and faint drop-out.
// Positions and sheet cell offsets are registered for the sprite renderer.
module back_sprite_ctrl #(
   parameter int unsigned CELL_W     = 66,
   parameter int unsigned CELL_H     = 67,
   parameter int unsigned COLS       = 14,
   parameter int unsigned START_X    = 0,
   parameter int unsigned HOME_X     = 100,
   parameter int unsigned HOME_Y     = 300,
   parameter int unsigned SLIDE_STEP = 8,
   parameter int unsigned FAINT_STEP = 4
) (
   input  logic        pixel_clk_in,
   input  logic        rst_n_in,
   input  logic        vsync_in,
   input  logic        start_in,
   input  logic [4:0]  species_in,
   input  logic        hit_in,
   input  logic        faint_in,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   output logic [9:0]  sprite_sel_x,
   output logic [8:0]  sprite_sel_y,
   output logic        visible_out,
   output logic        busy_out,
   output logic        done_out
);

   typedef enum logic [2:0] {StHidden, StSlideIn, StIdle, StHit, StFaint} state_e;

   state_e      r_state, w_state_nxt;
   logic        r_vsync_d;
   logic [10:0] r_x, w_x_d;
   logic [9:0]  r_y, w_y_d;
   logic [9:0]  r_sel_x, w_sel_x_d;
   logic [8:0]  r_sel_y, w_sel_y_d;
   logic        r_visible, w_visible_d;
   logic        r_busy, w_busy_d;
   logic        r_done, w_done_d;
   logic [4:0]  r_idle_cnt, w_idle_cnt_d;
   logic [3:0]  r_hit_cnt, w_hit_cnt_d;

   logic        w_tick;
   logic [11:0] w_x_sum;
   logic [10:0] w_x_step;
   logic        w_x_home;
   logic [10:0] w_y_drop;
   logic        w_y_gone;
   logic [4:0]  w_col;
   logic        w_row;

   assign w_tick   = vsync_in & ~r_vsync_d;
   assign w_x_sum  = {1'b0, r_x} + 12'(SLIDE_STEP);
   assign w_x_step = (w_x_sum >= 12'(HOME_X)) ? 11'(HOME_X) : w_x_sum[10:0];
   assign w_x_home = (w_x_step == 11'(HOME_X));
   assign w_y_drop = {1'b0, r_y} + 11'(FAINT_STEP);
   assign w_y_gone = (w_y_drop >= 11'(HOME_Y + CELL_H));

   // Out-of-range species fall back to cell 0.
   always_comb begin
      w_col = 5'd0;
      w_row = 1'b0;
      if (species_in < 5'(COLS)) begin
         w_col = species_in;
      end else if (species_in < 5'(2 * COLS)) begin
         w_col = species_in - 5'(COLS);
         w_row = 1'b1;
      end
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state <= StHidden;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         StHidden:  if (start_in) w_state_nxt = StSlideIn;
         StSlideIn: begin
            if (faint_in)                  w_state_nxt = StFaint;
            else if (w_tick && w_x_home)   w_state_nxt = StIdle;
         end
         StIdle: begin
            if (faint_in)    w_state_nxt = StFaint;
            else if (hit_in) w_state_nxt = StHit;
         end
         StHit: begin
            if (faint_in)                           w_state_nxt = StFaint;
            else if (w_tick && r_hit_cnt == 4'hF)   w_state_nxt = StIdle;
         end
         StFaint:   if (w_tick && w_y_gone) w_state_nxt = StHidden;
         default:   w_state_nxt = StHidden;
      endcase
   end

   always_comb begin
      w_x_d        = r_x;
      w_y_d        = r_y;
      w_sel_x_d    = r_sel_x;
      w_sel_y_d    = r_sel_y;
      w_visible_d  = r_visible;
      w_done_d     = 1'b0;
      w_idle_cnt_d = r_idle_cnt;
      w_hit_cnt_d  = r_hit_cnt;
      w_busy_d     = (w_state_nxt == StSlideIn) || (w_state_nxt == StHit)
                     || (w_state_nxt == StFaint);
      unique case (r_state)
         StHidden: begin
            if (start_in) begin
               w_x_d       = 11'(START_X);
               w_y_d       = 10'(HOME_Y);
               w_visible_d = 1'b1;
               w_sel_x_d   = 10'(32'(w_col) * CELL_W);
               w_sel_y_d   = w_row ? 9'(CELL_H) : 9'd0;
            end
         end
         StSlideIn: begin
            if (faint_in) begin
               w_visible_d = 1'b1;
            end else if (w_tick) begin
               w_x_d = w_x_step;
               if (w_x_home) begin
                  w_done_d     = 1'b1;
                  w_idle_cnt_d = 5'd0;
               end
            end
         end
         StIdle: begin
            if (faint_in) begin
               w_visible_d = 1'b1;
            end else if (hit_in) begin
               w_hit_cnt_d = 4'd0;
               w_y_d       = 10'(HOME_Y);
            end else if (w_tick) begin
               // Bob follows the pre-increment count: 16 frames low, 16 high.
               w_y_d        = 10'(HOME_Y) + {9'd0, r_idle_cnt[4]};
               w_idle_cnt_d = r_idle_cnt + 5'd1;
            end
         end
         StHit: begin
            if (faint_in) begin
               w_visible_d = 1'b1;
            end else if (w_tick) begin
               w_hit_cnt_d = r_hit_cnt + 4'd1;
               if (r_hit_cnt == 4'hF) begin
                  w_visible_d  = 1'b1;
                  w_idle_cnt_d = 5'd0;
               end else if (r_hit_cnt[1:0] == 2'd3) begin
                  w_visible_d = ~r_visible;
               end
            end
         end
         StFaint: begin
            if (w_tick) begin
               w_y_d = w_y_drop[9:0];
               if (w_y_gone) begin
                  w_visible_d = 1'b0;
                  w_done_d    = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_vsync_d  <= 1'b0;
         r_x        <= 11'(START_X);
         r_y        <= 10'(HOME_Y);
         r_sel_x    <= 10'd0;
         r_sel_y    <= 9'd0;
         r_visible  <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_idle_cnt <= 5'd0;
         r_hit_cnt  <= 4'd0;
      end else begin
         r_vsync_d  <= vsync_in;
         r_x        <= w_x_d;
         r_y        <= w_y_d;
         r_sel_x    <= w_sel_x_d;
         r_sel_y    <= w_sel_y_d;
         r_visible  <= w_visible_d;
         r_busy     <= w_busy_d;
         r_done     <= w_done_d;
         r_idle_cnt <= w_idle_cnt_d;
         r_hit_cnt  <= w_hit_cnt_d;
      end
   end

   assign x_out        = r_x;
   assign y_out        = r_y;
   assign sprite_sel_x = r_sel_x;
   assign sprite_sel_y = r_sel_y;
   assign visible_out  = r_visible;
   assign busy_out     = r_busy;
   assign done_out     = r_done;

endmodule

// File: doc/back_sprite_ctrl.md
BACK_SPRITE_CTRL -- requirements
Module: back_sprite_ctrl

Interface
REQ-001 Params SHALL be: CELL_W 66, sheet cell width px; CELL_H 67, sheet cell height px; COLS 14, cells per sheet row (sheet has exactly 2 rows); START_X 0, slide-in start x; HOME_X 100, resting x; HOME_Y 300, resting y; SLIDE_STEP 8, px per frame in slide; FAINT_STEP 4, px per frame in faint.
REQ-002 pixel_clk_in  in  1  sole clock, all logic rising-edge.
REQ-003 rst_n_in  in  1  reset, asynchronous assert, active-low.
REQ-004 vsync_in  in  1  frame sync; each rising edge is one frame tick.
REQ-005 start_in  in  1  one-cycle request: show sprite with slide-in.
REQ-006 species_in  in  5  sheet cell index, sampled on accepted start_in.
REQ-007 hit_in  in  1  one-cycle request: damage blink.
REQ-008 faint_in  in  1  one-cycle request: faint drop-out.
REQ-009 x_out  out  11  sprite left x, feeds renderer x_in.
REQ-010 y_out  out  10  sprite top y, feeds renderer y_in.
REQ-011 sprite_sel_x  out  10  sheet x offset of selected cell.
REQ-012 sprite_sel_y  out  9  sheet y offset of selected cell.
REQ-013 visible_out  out  1  1 = renderer output to be composited.
REQ-014 busy_out  out  1  1 in SLIDE_IN, HIT, FAINT.
REQ-015 done_out  out  1  one-cycle completion pulse.

Function
REQ-016 All outputs SHALL be registered; frame tick = vsync_in high while its one-cycle-delayed copy is low, internal single-cycle pulse.
REQ-017 FSM states SHALL be HIDDEN, SLIDE_IN, IDLE, HIT, FAINT.
REQ-018 HIDDEN + start_in: latch species, x_out<=START_X, y_out<=HOME_Y, visible_out<=1, go SLIDE_IN next cycle; start_in in any other state ignored.
REQ-019 Cell select on latch: species<COLS -> col=species,row=0; COLS<=species<2*COLS -> col=species-COLS,row=1; species>=2*COLS -> col=0,row=0; sprite_sel_x=col*CELL_W, sprite_sel_y=row*CELL_H, held until next accepted start.
REQ-020 SLIDE_IN per tick: x_out<=min(x_out+SLIDE_STEP, HOME_X), 12-bit intermediate; on the tick x_out reaches HOME_X: go IDLE, done_out pulses next cycle.
REQ-021 IDLE: 5-bit frame counter; y_out=HOME_Y+1 while counter[4]=1, else HOME_Y (1-px bob, 32-frame period); counter cleared on IDLE entry.
REQ-022 IDLE + hit_in: go HIT, 4-bit tick counter cleared, y_out<=HOME_Y; hit_in outside IDLE ignored.
REQ-023 HIT: visible_out toggles every 4th tick (ticks 4,8,12,16); after 16th tick visible_out<=1, go IDLE; no done_out.
REQ-024 faint_in in SLIDE_IN, IDLE or HIT: go FAINT, x_out held, visible_out<=1; faint_in in HIDDEN or FAINT ignored.
REQ-025 Same-cycle hit_in+faint_in SHALL take faint; same-cycle start_in+faint_in in HIDDEN SHALL take start.
REQ-026 FAINT per tick: y_out<=y_out+FAINT_STEP; when new y_out>=HOME_Y+CELL_H: visible_out<=0, go HIDDEN, done_out pulses once.
REQ-027 Event requests arriving on a tick cycle SHALL transition that cycle; the tick's motion update of the old state is discarded.
REQ-028 busy_out SHALL equal (state in SLIDE_IN, HIT, FAINT), registered with state.

Reset
REQ-029 rst_n_in low SHALL immediately force: state HIDDEN, x_out=START_X, y_out=HOME_Y, sprite_sel_x=0, sprite_sel_y=0, visible_out=0, busy_out=0, done_out=0, all counters and vsync delay =0.
REQ-030 Reset release SHALL need no tick; first start_in accepted the first cycle after release.
REQ-031 Reset mid-animation SHALL abort with no done_out pulse.

Verification
REQ-032 species 17 + start_in from HIDDEN -> sel_x=198, sel_y=67, visible 1, busy 1; species 30 -> sel 0,0.
REQ-033 Slide defaults: 13 ticks -> x 8,16..96,100; IDLE on tick 13, done_out exactly one cycle, busy 0.
REQ-034 IDLE 32 ticks -> y_out 300 x16 then 301 x16; hit_in -> visible 1,1,1,0 ... back to 1 after tick 16, IDLE, no done.
REQ-035 faint_in+hit_in same cycle in IDLE -> FAINT; y 304..368, tick 17 visible 0, HIDDEN, one done pulse.
REQ-036 rst_n_in low at slide tick 5 (x=40) -> all outputs reset values same cycle, no done; start_in after release restarts at x=0.
